// File: rtl/iq_sequencer_pkg.sv
// Shared definitions for the IQ sequencer: instruction encodings, pipeline
// latencies, default rebase thresholds and the sequencer state type.
package iq_sequencer_pkg;

  localparam logic [1:0] INSTR_TYPE_DMA     = 2'd0;
  localparam logic [1:0] INSTR_TYPE_REGFILE = 2'd1;
  localparam logic [1:0] INSTR_TYPE_ARITH   = 2'd2;

  localparam int unsigned DMA_INSTRUCTION_LATENCY     = 4;
  localparam int unsigned REGFILE_INSTRUCTION_LATENCY = 1;
  localparam int unsigned ARITH_INSTRUCTION_LATENCY   = 10;

  localparam int unsigned SEQ_POS_BITS        = 16;
  localparam logic [15:0] SEQ_DRAIN_THRESHOLD = 16'hFF00;
  localparam int unsigned SEQ_REBASE_CYCLES   = 2;

  typedef enum logic [1:0] {
    SEQ_RUN    = 2'd0,
    SEQ_DRAIN  = 2'd1,
    SEQ_SETTLE = 2'd2,
    SEQ_REBASE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/iq_sequencer_perf.sv
// Performance counters for the IQ sequencer: rebase entries and stall cycles
// (both saturating) and pop strobes (wrapping). Only built with IQ_SEQ_PERF_EN.
module iq_seq_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_rebase_entry,
  input  logic        i_stall,
  input  logic        i_pop,
  output logic [15:0] o_perf_rebase_count,
  output logic [31:0] o_perf_stall_cycles,
  output logic [31:0] o_perf_pop_count
);

  logic [15:0] r_rebase_count;
  logic [31:0] r_stall_cycles;
  logic [31:0] r_pop_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rebase_count <= '0;
      r_stall_cycles <= '0;
      r_pop_count    <= '0;
    end else begin
      if (i_rebase_entry && (r_rebase_count != '1))
        r_rebase_count <= r_rebase_count + 16'd1;
      if (i_stall && (r_stall_cycles != '1))
        r_stall_cycles <= r_stall_cycles + 32'd1;
      if (i_pop)
        r_pop_count <= r_pop_count + 32'd1;
    end
  end

  assign o_perf_rebase_count = r_rebase_count;
  assign o_perf_stall_cycles = r_stall_cycles;
  assign o_perf_pop_count    = r_pop_count;

endmodule

// File: rtl/iq_sequencer.sv
// Gates decoder pushes / execution pops on the instruction queue and rebases
// the IQ before its positions saturate. Optional counters: `define IQ_SEQ_PERF_EN.
module iq_sequencer
  import iq_sequencer_pkg::*;
#(
  parameter int unsigned           POS_BITS        = SEQ_POS_BITS,
  parameter logic [POS_BITS-1:0]   DRAIN_THRESHOLD = POS_BITS'(SEQ_DRAIN_THRESHOLD),
  parameter int unsigned           RETIRE_WAIT     = ARITH_INSTRUCTION_LATENCY,
  parameter int unsigned           REBASE_CYCLES   = SEQ_REBASE_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_dec_valid,
  output logic                o_dec_ready,
  output logic                o_iq_we,
  output logic                o_iq_re,
  input  logic                i_iq_empty,
  input  logic                i_iq_needs_reset,
  input  logic [POS_BITS-1:0] i_iq_insert_pos,
  input  logic [POS_BITS-1:0] i_iq_read_pos,
  output logic                o_iq_reset,
  input  logic                i_exec_ready,
  output logic [1:0]          o_seq_state
`ifdef IQ_SEQ_PERF_EN
  ,
  output logic [15:0]         o_perf_rebase_count,
  output logic [31:0]         o_perf_stall_cycles,
  output logic [31:0]         o_perf_pop_count
`endif
);

  localparam int unsigned RW_BITS = $clog2(RETIRE_WAIT + 1);
  localparam int unsigned RB_BITS = $clog2(REBASE_CYCLES + 1);
  localparam logic [RW_BITS-1:0] RETIRE_LOAD = RW_BITS'(RETIRE_WAIT - 1);
  localparam logic [RB_BITS-1:0] REBASE_LOAD = RB_BITS'(REBASE_CYCLES - 1);

  seq_state_t          r_state;
  seq_state_t          w_state_nxt;
  logic [RW_BITS-1:0]  r_retire_cnt;
  logic [RW_BITS-1:0]  w_retire_nxt;
  logic [RB_BITS-1:0]  r_rebase_cnt;
  logic [RB_BITS-1:0]  w_rebase_nxt;
  logic                r_iq_reset;
  logic                w_iq_reset_nxt;
  logic                w_drain_req;
  logic                w_dec_ready;
  logic                w_iq_we;
  logic                w_iq_re;

  assign w_drain_req = i_iq_needs_reset
                     | (i_iq_insert_pos >= DRAIN_THRESHOLD)
                     | (i_iq_read_pos   >= DRAIN_THRESHOLD);

  // iq_reset is registered alongside the state so the IQ sees a clean strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= SEQ_RUN;
      r_retire_cnt <= '0;
      r_rebase_cnt <= '0;
      r_iq_reset   <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_retire_cnt <= w_retire_nxt;
      r_rebase_cnt <= w_rebase_nxt;
      r_iq_reset   <= w_iq_reset_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_retire_nxt   = r_retire_cnt;
    w_rebase_nxt   = r_rebase_cnt;
    w_iq_reset_nxt = 1'b0;
    case (r_state)
      SEQ_RUN: begin
        if (w_drain_req)
          w_state_nxt = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        if (i_iq_empty && !w_iq_re) begin
          w_state_nxt  = SEQ_SETTLE;
          w_retire_nxt = RETIRE_LOAD;
        end
      end
      SEQ_SETTLE: begin
        if (r_retire_cnt == '0) begin
          w_state_nxt    = SEQ_REBASE;
          w_rebase_nxt   = REBASE_LOAD;
          w_iq_reset_nxt = 1'b1;
        end else begin
          w_retire_nxt = r_retire_cnt - RW_BITS'(1);
        end
      end
      SEQ_REBASE: begin
        if (r_rebase_cnt == '0) begin
          w_state_nxt = SEQ_RUN;
        end else begin
          w_rebase_nxt   = r_rebase_cnt - RB_BITS'(1);
          w_iq_reset_nxt = 1'b1;
        end
      end
      default: w_state_nxt = SEQ_RUN;
    endcase
  end

  // A bundle offered in the cycle drain_req rises is refused, keeping the push zero-latency.
  always_comb begin
    w_dec_ready = (r_state == SEQ_RUN) && !w_drain_req && !r_iq_reset;
    w_iq_we     = i_dec_valid && w_dec_ready;
    w_iq_re     = ((r_state == SEQ_RUN) || (r_state == SEQ_DRAIN))
                  && !i_iq_empty && i_exec_ready && !r_iq_reset;
  end

  assign o_dec_ready = w_dec_ready;
  assign o_iq_we     = w_iq_we;
  assign o_iq_re     = w_iq_re;
  assign o_iq_reset  = r_iq_reset;
  assign o_seq_state = r_state;

`ifdef IQ_SEQ_PERF_EN
  logic w_rebase_entry;
  logic w_stall;

  assign w_rebase_entry = (r_state == SEQ_SETTLE) && (w_state_nxt == SEQ_REBASE);
  assign w_stall        = i_dec_valid && !w_dec_ready;

  iq_seq_perf u_perf (
    .clk                 (clk),
    .reset               (reset),
    .i_rebase_entry      (w_rebase_entry),
    .i_stall             (w_stall),
    .i_pop               (w_iq_re),
    .o_perf_rebase_count (o_perf_rebase_count),
    .o_perf_stall_cycles (o_perf_stall_cycles),
    .o_perf_pop_count    (o_perf_pop_count)
  );
`endif

endmodule

// File: tb/tb_iq_sequencer.sv
// Directed self-checking bench for iq_sequencer: reset, push/pop gating,
// drain/settle/rebase sequencing, mid-rebase reset and (with IQ_SEQ_PERF_EN) counters.
module tb_iq_sequencer;
  import iq_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        dec_valid;
  logic        dec_ready;
  logic        iq_we;
  logic        iq_re;
  logic        iq_empty;
  logic        iq_needs_reset;
  logic [15:0] iq_insert_pos;
  logic [15:0] iq_read_pos;
  logic        iq_reset;
  logic        exec_ready;
  logic [1:0]  seq_state;
`ifdef IQ_SEQ_PERF_EN
  logic [15:0] perf_rebase_count;
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_pop_count;
`endif

  int checks    = 0;
  int failures  = 0;
  int expPops   = 0;
  int expStall  = 0;
  int expRebase = 0;
  seq_state_t lastState = SEQ_RUN;

  always #5 clk = ~clk;

  iq_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .i_dec_valid      (dec_valid),
    .o_dec_ready      (dec_ready),
    .o_iq_we          (iq_we),
    .o_iq_re          (iq_re),
    .i_iq_empty       (iq_empty),
    .i_iq_needs_reset (iq_needs_reset),
    .i_iq_insert_pos  (iq_insert_pos),
    .i_iq_read_pos    (iq_read_pos),
    .o_iq_reset       (iq_reset),
    .i_exec_ready     (exec_ready),
    .o_seq_state      (seq_state)
`ifdef IQ_SEQ_PERF_EN
    ,
    .o_perf_rebase_count (perf_rebase_count),
    .o_perf_stall_cycles (perf_stall_cycles),
    .o_perf_pop_count    (perf_pop_count)
`endif
  );

  task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic dv, input logic empty, input logic exec,
                               input logic needsReset, input logic [15:0] insPos,
                               input logic [15:0] rdPos);
    dec_valid      = dv;
    iq_empty       = empty;
    exec_ready     = exec;
    iq_needs_reset = needsReset;
    iq_insert_pos  = insPos;
    iq_read_pos    = rdPos;
  endtask

  // Checks one cycle's outputs, updates the counter model, then advances to the next cycle.
  task automatic checkOutput(input string tag, input seq_state_t eState, input logic eIqReset,
                             input logic eReady, input logic eWe, input logic eRe);
    #1;
    checkValue({tag, ".state"},    32'(seq_state), 32'(eState));
    checkValue({tag, ".iq_reset"}, 32'(iq_reset),  32'(eIqReset));
    checkValue({tag, ".dec_ready"},32'(dec_ready), 32'(eReady));
    checkValue({tag, ".iq_we"},    32'(iq_we),     32'(eWe));
    checkValue({tag, ".iq_re"},    32'(iq_re),     32'(eRe));
    if (reset) begin
      expPops   = 0;
      expStall  = 0;
      expRebase = 0;
      lastState = SEQ_RUN;
    end else begin
      if (eRe) expPops++;
      if (dec_valid && !eReady) expStall++;
      if (eState == SEQ_REBASE && lastState != SEQ_REBASE) expRebase++;
      lastState = eState;
    end
    @(posedge clk);
    #1;
  endtask

  // Insert position hits the threshold with three entries still queued.
  task automatic drainScenario(input string tag);
    int entries;
    int obsPops;
    logic exec;
    logic empty;
    entries = 3;
    obsPops = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'hFF00, 16'h0000);
    checkOutput({tag, ".hit"}, SEQ_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      exec  = (k % 2 == 0);
      empty = (entries == 0);
      applyStimulus(1'b1, empty, exec, 1'b0, 16'hFF00, 16'h0000);
      #1;
      obsPops += int'(iq_re);
      #0;
      checkOutput({tag, ".drain"}, SEQ_DRAIN, 1'b0, 1'b0, 1'b0, exec && !empty);
      if (exec && !empty) entries--;
      if (empty) break;
    end
    checkValue({tag, ".popcount"}, 32'(obsPops), 32'd3);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, (i == 3) ? 1'b0 : 1'b1, 1'b1, 1'b0, 16'hFF00, 16'h0000);
      checkOutput({tag, ".settle"}, SEQ_SETTLE, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
      checkOutput({tag, ".rebase"}, SEQ_REBASE, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    checkOutput({tag, ".resume"}, SEQ_RUN, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    checkOutput({tag, ".idle"}, SEQ_RUN, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and release
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    checkOutput("rst1", SEQ_RUN, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("rst2", SEQ_RUN, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    checkOutput("rst.release", SEQ_RUN, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("idle", SEQ_RUN, 1'b0, 1'b1, 1'b0, 1'b0);

    // Pushes and pops with low positions
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0010, 16'h0008);
      checkOutput("push", SEQ_RUN, 1'b0, 1'b1, 1'b1, 1'b1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'hFEFF, 16'hFEFF);
    checkOutput("below_thr", SEQ_RUN, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    checkOutput("idle2", SEQ_RUN, 1'b0, 1'b1, 1'b0, 1'b0);

    drainScenario("s3");

    // Needs-reset with an empty IQ
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000);
    checkOutput("s4.hit", SEQ_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s4.drain", SEQ_DRAIN, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++)
      checkOutput("s4.settle", SEQ_SETTLE, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    checkOutput("s4.rebase", SEQ_REBASE, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s4.rebase", SEQ_REBASE, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s4.resume", SEQ_RUN, 1'b0, 1'b1, 1'b0, 1'b0);

    // Read position trips the drain, reset lands at settle count 4
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'hFF00);
    checkOutput("s5.hit", SEQ_RUN, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("s5.drain", SEQ_DRAIN, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++)
      checkOutput("s5.settle", SEQ_SETTLE, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    checkOutput("s5.rst", SEQ_SETTLE, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h0000);
    checkOutput("s5.after", SEQ_RUN, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("s5.idle", SEQ_RUN, 1'b0, 1'b1, 1'b0, 1'b0);

    drainScenario("s6a");
    drainScenario("s6b");

`ifdef IQ_SEQ_PERF_EN
    checkValue("perf.rebase", 32'(perf_rebase_count), 32'(expRebase));
    checkValue("perf.rebase2", 32'(perf_rebase_count), 32'd2);
    checkValue("perf.pops", perf_pop_count, 32'(expPops));
    checkValue("perf.stall", perf_stall_cycles, 32'(expStall));
`endif

    $display("[TB] model totals pops=%0d stall=%0d rebase=%0d", expPops, expStall, expRebase);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
